// File: rtl/branch_unit.sv
// Branch decision for the accumulator CPU: combinational PC-load enable,
// plus a registered copy of it and a saturating taken-branch counter.
module branch_unit #(
    parameter logic [2:0] OP_JMP = 3'b100,
    parameter logic [2:0] OP_JZ  = 3'b101,
    parameter logic [2:0] OP_JC  = 3'b110,
    parameter int         CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [2:0]       op_i,
    input  logic             flag_z_i,
    input  logic             flag_c_i,
    input  logic             ctrl_jmp_i,
    input  logic             clr_cnt_i,
    output logic             branch_o,
    output logic             branch_q_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    logic             w_cond;
    logic             w_sat;
    logic             r_branch_q;
    logic [CNT_W-1:0] r_cnt;

    // Exact case matching: opcodes carrying X/Z bits fall through to default.
    always_comb begin
        w_cond = 1'b0;
        case (op_i)
            OP_JMP:  w_cond = 1'b1;
            OP_JZ:   w_cond = flag_z_i;
            OP_JC:   w_cond = flag_c_i;
            default: w_cond = 1'b0;
        endcase
    end

    assign branch_o = ctrl_jmp_i & w_cond;
    assign w_sat    = &r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_branch_q <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_branch_q <= branch_o;
            // Clear has priority over a same-cycle taken branch.
            if (clr_cnt_i)
                r_cnt <= '0;
            else if (branch_o && !w_sat)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign branch_q_o  = r_branch_q;
    assign taken_cnt_o = r_cnt;

endmodule

// File: tb/tb_branch_unit.sv
// Randomized scoreboard bench for branch_unit; a second instance with a
// 2-bit counter exercises saturation and clear-vs-branch priority.
module tb_branch_unit;

    typedef struct {
        bit br;
        bit q;
        int cnt;
        int cnt2;
    } exp_t;

    logic        clk;
    logic        rst_ni;
    logic [2:0]  op_i;
    logic        flag_z_i, flag_c_i, ctrl_jmp_i, clr_cnt_i;
    logic        branch_o, branch_q_o, branch2_o, branch2_q_o;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_q = 0, m_cnt = 0, m_cnt2 = 0;
    bit   done = 0;

    branch_unit #(.CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .op_i(op_i), .flag_z_i(flag_z_i),
        .flag_c_i(flag_c_i), .ctrl_jmp_i(ctrl_jmp_i), .clr_cnt_i(clr_cnt_i),
        .branch_o(branch_o), .branch_q_o(branch_q_o), .taken_cnt_o(cnt)
    );

    branch_unit #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .op_i(op_i), .flag_z_i(flag_z_i),
        .flag_c_i(flag_c_i), .ctrl_jmp_i(ctrl_jmp_i), .clr_cnt_i(clr_cnt_i),
        .branch_o(branch2_o), .branch_q_o(branch2_q_o), .taken_cnt_o(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rmode: 0 normal, 1 reset held low across the next edge, 2 reset pulsed between edges
    task automatic drive(input logic [2:0] op, input bit z, input bit c,
                         input bit j, input bit clr, input int rmode);
        bit br;
        exp_t e;
        @(negedge clk);
        op_i = op; flag_z_i = z; flag_c_i = c; ctrl_jmp_i = j; clr_cnt_i = clr;
        if (rmode != 0) begin
            rst_ni = 1'b0;
            m_q = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            rst_ni = 1'b1;
        end
        br = j && (op == 3'd4 || (op == 3'd5 && z) || (op == 3'd6 && c));
        e.br = br; e.q = (m_q != 0); e.cnt = m_cnt; e.cnt2 = m_cnt2;
        sb.push_back(e);
        if (rmode == 2) begin
            #4 rst_ni = 1'b1;
        end
        if (rmode != 1) begin
            m_q = br ? 1 : 0;
            if (clr) begin
                m_cnt = 0; m_cnt2 = 0;
            end else if (br) begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (m_cnt2 < 3)    m_cnt2 = m_cnt2 + 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a settled output, compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("branch_o",      int'(branch_o),    int'(e.br));
                chk("branch_q_o",    int'(branch_q_o),  int'(e.q));
                chk("taken_cnt_o",   int'(cnt),         e.cnt);
                chk("branch2_o",     int'(branch2_o),   int'(e.br));
                chk("branch2_q_o",   int'(branch2_q_o), int'(e.q));
                chk("taken_cnt2_o",  int'(cnt2),        e.cnt2);
            end
        end
    end

    initial begin
        logic [2:0] op;
        rst_ni = 1'b0; op_i = '0; flag_z_i = 0; flag_c_i = 0; ctrl_jmp_i = 0; clr_cnt_i = 0;
        // reset state, with a taken JMP presented so branch_o is live during reset
        drive(3'b100, 0, 0, 1, 0, 1);
        drive(3'b100, 0, 0, 1, 0, 1);
        // directed plan
        drive(3'b100, 0, 0, 1, 0, 0);
        drive(3'b010, 0, 1, 1, 0, 0);
        for (int o = 0; o < 8; o++)
            if (o < 4 || o == 7)
                for (int f = 0; f < 8; f++) begin
                    op = 3'(o);
                    drive(op, f[0], f[1], f[2], 0, 0);
                end
        drive(3'b101, 1, 0, 0, 0, 0);
        drive(3'b101, 0, 1, 1, 0, 0);
        drive(3'b101, 1, 0, 1, 0, 0);
        drive(3'b110, 0, 0, 1, 0, 0);
        drive(3'b110, 1, 0, 1, 0, 0);
        drive(3'b110, 0, 1, 1, 0, 0);
        drive(3'b110, 1, 1, 1, 0, 0);
        drive(3'b100, 1, 1, 1, 0, 2);
        drive(3'b100, 0, 1, 1, 0, 0);
        // saturation of the 2-bit counter, then clear beating a taken branch
        drive(3'b100, 0, 0, 1, 1, 0);
        for (int k = 0; k < 5; k++) drive(3'b100, 0, 0, 1, 0, 0);
        drive(3'b100, 0, 0, 1, 1, 0);
        drive(3'b000, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) != 0) op = 3'(4 + $urandom_range(0, 2));
            drive(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  ($urandom_range(0, 49) == 0) ? 2 : 0);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
